ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. It is the transmit counterpart of the existing ps2host receiver.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Drives the shared ps2_clk/ps2_data lines open-drain and reports completion, device NACK or timeout.
- Runs on dot_clk beside ps2host. rx_inhibit keeps the receiver from decoding host-driven frames.

---
 rtl/ps2_host_tx_if.sv | 31 +++
 rtl/ps2_host_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-side handshake between a command source and the PS/2 transmitter.
// The master issues single-byte requests; the slave (the transmitter)
// reports busy, completion and error back to it.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx_error_tick;
    logic       rx_inhibit;

    // Command source side: drives the byte and the start request
    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy,
        input  tx_done_tick,
        input  tx_error_tick,
        input  rx_inhibit
    );

    // Transmitter side: consumes the request, reports frame status
    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy,
        output tx_done_tick,
        output tx_error_tick,
        output rx_inhibit
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// by inhibiting the bus, issuing a request-to-send and then shifting the
// frame out on device-generated clock falls. The shared lines are driven
// open-drain through the *_oe outputs (1 = pull low). rx_inhibit tells the
// companion receiver to ignore the bus while this block owns it.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 800,
    parameter int TIMEOUT_CYCLES = 160000,
    parameter int FILTER_LEN     = 8
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave host,
    input  logic         ps2c_i,
    input  logic         ps2d_i,
    output logic         ps2c_oe,
    output logic         ps2d_oe
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    // Synchronised and filtered versions of the two bus lines
    logic [1:0]            c_sync;
    logic [1:0]            d_sync;
    logic [FILTER_LEN-1:0] c_hist;
    logic [FILTER_LEN-1:0] d_hist;
    logic                  c_filt;
    logic                  d_filt;
    logic                  c_filt_d;
    logic                  c_fall;
    logic                  c_edge;

    // FSM registers and their next-state values
    state_t          state_q, state_n;
    logic [9:0]      shift_q, shift_n;
    logic [3:0]      edge_cnt_q, edge_cnt_n;
    logic [IW-1:0]   inh_cnt_q, inh_cnt_n;
    logic [TW-1:0]   timer_q, timer_n;
    logic            ack_ok_q, ack_ok_n;
    logic            c_oe_q, c_oe_n;
    logic            d_oe_q, d_oe_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;
    logic            err_q, err_n;
    logic            timing_state;

    // Two-flop synchronisers; idle bus level is high, so preset to 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c_i};
            d_sync <= {d_sync[0], ps2d_i};
        end
    end

    // Sample-history filter: a line only changes after FILTER_LEN equal samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_hist <= '1;
            d_hist <= '1;
            c_filt <= 1'b1;
            d_filt <= 1'b1;
        end else begin
            c_hist <= {c_hist[FILTER_LEN-2:0], c_sync[1]};
            d_hist <= {d_hist[FILTER_LEN-2:0], d_sync[1]};
            if (&c_hist) begin
                c_filt <= 1'b1;
            end else if (~|c_hist) begin
                c_filt <= 1'b0;
            end
            if (&d_hist) begin
                d_filt <= 1'b1;
            end else if (~|d_hist) begin
                d_filt <= 1'b0;
            end
        end
    end

    // Registered edge detection on the filtered clock: fall pulse plus any-edge for the watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_filt_d <= 1'b1;
            c_fall   <= 1'b0;
            c_edge   <= 1'b0;
        end else begin
            c_filt_d <= c_filt;
            c_fall   <= c_filt_d & ~c_filt;
            c_edge   <= c_filt_d ^ c_filt;
        end
    end

    // The watchdog only runs once the device is expected to be clocking
    assign timing_state = (state_q == RELEASE) || (state_q == SEND) ||
                          (state_q == ACK)     || (state_q == WAIT_IDLE);

    // Next-state and registered-output logic; timeout overrides everything else
    always_comb begin
        state_n    = state_q;
        shift_n    = shift_q;
        edge_cnt_n = edge_cnt_q;
        inh_cnt_n  = inh_cnt_q;
        timer_n    = timer_q;
        ack_ok_n   = ack_ok_q;
        c_oe_n     = c_oe_q;
        d_oe_n     = d_oe_q;
        busy_n     = busy_q;
        done_n     = 1'b0;
        err_n      = 1'b0;

        if (timing_state) begin
            if (c_edge) begin
                timer_n = '0;
            end else begin
                timer_n = timer_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                c_oe_n = 1'b0;
                d_oe_n = 1'b0;
                busy_n = 1'b0;
                if (host.tx_start) begin
                    shift_n    = {1'b1, ~^host.tx_data, host.tx_data};
                    edge_cnt_n = '0;
                    inh_cnt_n  = '0;
                    timer_n    = '0;
                    ack_ok_n   = 1'b0;
                    busy_n     = 1'b1;
                    c_oe_n     = 1'b1;
                    state_n    = INHIBIT;
                end
            end
            INHIBIT: begin
                c_oe_n = 1'b1;
                d_oe_n = 1'b0;
                if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
                    d_oe_n  = 1'b1;
                    timer_n = '0;
                    state_n = RELEASE;
                end else begin
                    inh_cnt_n = inh_cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                c_oe_n  = 1'b0;
                timer_n = '0;
                state_n = SEND;
            end
            SEND: begin
                if (c_fall) begin
                    d_oe_n     = ~shift_q[0];
                    shift_n    = {1'b0, shift_q[9:1]};
                    edge_cnt_n = edge_cnt_q + 4'd1;
                    if (edge_cnt_q == 4'd9) begin
                        timer_n = '0;
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                if (c_fall) begin
                    ack_ok_n = ~d_filt;
                    timer_n  = '0;
                    state_n  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (c_filt && d_filt) begin
                    done_n  = ack_ok_q;
                    err_n   = ~ack_ok_q;
                    busy_n  = 1'b0;
                    timer_n = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                c_oe_n  = 1'b0;
                d_oe_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase

        if (timing_state && (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
            c_oe_n  = 1'b0;
            d_oe_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            err_n   = 1'b1;
            timer_n = '0;
            state_n = IDLE;
        end
    end

    // State register; reset releases both lines without waiting for a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            edge_cnt_q <= '0;
            inh_cnt_q  <= '0;
            timer_q    <= '0;
            ack_ok_q   <= 1'b0;
            c_oe_q     <= 1'b0;
            d_oe_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            shift_q    <= shift_n;
            edge_cnt_q <= edge_cnt_n;
            inh_cnt_q  <= inh_cnt_n;
            timer_q    <= timer_n;
            ack_ok_q   <= ack_ok_n;
            c_oe_q     <= c_oe_n;
            d_oe_q     <= d_oe_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            err_q      <= err_n;
        end
    end

    assign ps2c_oe            = c_oe_q;
    assign ps2d_oe            = d_oe_q;
    assign host.tx_busy       = busy_q;
    assign host.rx_inhibit    = busy_q;
    assign host.tx_done_tick  = done_q;
    assign host.tx_error_tick = err_q;

endmodule
